// File: rtl/prng_sched_if.sv
// Request/grant bus between the PRNG scheduler and its requesters.
interface prng_sched_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0] req;
    logic             reseed_req;
    logic [127:0]     prng_data;
    logic             prng_rst_n;
    logic [N_REQ-1:0] gnt;
    logic             rvalid;
    logic [127:0]     rdata;
    logic             busy;
    logic [31:0]      word_cnt;

    modport slave (
        input  req, reseed_req, prng_data,
        output prng_rst_n, gnt, rvalid, rdata, busy, word_cnt
    );

    modport master (
        output req, reseed_req, prng_data,
        input  prng_rst_n, gnt, rvalid, rdata, busy, word_cnt
    );
endinterface

// File: rtl/prng_sched_ctrl.sv
// Shares one 128-bit PRNG among N_REQ requesters: reseed, warm-up discard,
// then round-robin one-word grants with periodic or requested reseeds.
module prng_sched_ctrl #(
    parameter int N_REQ         = 4,
    parameter int WARMUP        = 8,
    parameter int SEED_CYC      = 2,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic         clk,
    input  logic         rst,
    prng_sched_if.slave  bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] SEED  = 2'd0;
    localparam logic [1:0] WARM  = 2'd1;
    localparam logic [1:0] SERVE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             rvalid_q, rvalid_d;
    logic [127:0]     rdata_q, rdata_d;
    logic [31:0]      served_q, served_d;
    logic [31:0]      word_cnt_q, word_cnt_d;

    logic [N_REQ-1:0] elig;
    logic [PW:0]      pick_r;
    logic             reseed_due;

    // Returns {found, index}: first set bit of e scanning upward from p, wrapping.
    function automatic logic [PW:0] pick(input logic [N_REQ-1:0] e, input logic [PW-1:0] p);
        logic [PW:0]      r;
        logic [N_REQ-1:0] tmp;
        int               k;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k   = (int'(p) + i) % N_REQ;
            tmp = e >> k;
            if (tmp[0]) r = {1'b1, k[PW-1:0]};
        end
        return r;
    endfunction

    // The requester granted last cycle has not yet seen its gnt, so mask it.
    assign elig       = bus.req & ~gnt_q;
    assign pick_r     = pick(elig, ptr_q);
    assign reseed_due = bus.reseed_req ||
                        (RESEED_PERIOD != 0 && served_q >= 32'(RESEED_PERIOD));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        rvalid_d   = 1'b0;
        rdata_d    = rdata_q;
        served_d   = served_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            SEED: begin
                if (cnt_q == 32'(SEED_CYC - 1)) begin
                    state_d = WARM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WARM: begin
                if (cnt_q == 32'(WARMUP - 1)) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SERVE: begin
                if (reseed_due) begin
                    state_d  = SEED;
                    cnt_d    = '0;
                    served_d = '0;
                end else if (pick_r[PW]) begin
                    gnt_d[pick_r[PW-1:0]] = 1'b1;
                    rvalid_d   = 1'b1;
                    rdata_d    = bus.prng_data;
                    served_d   = served_q + 32'd1;
                    word_cnt_d = word_cnt_q + 32'd1;
                    ptr_d      = (pick_r[PW-1:0] == PW'(N_REQ - 1)) ? '0 : pick_r[PW-1:0] + 1'b1;
                end
            end
            default: begin
                state_d = SEED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEED;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            served_q   <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            served_q   <= served_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign bus.prng_rst_n = (state_q != SEED);
    assign bus.busy       = (state_q != SERVE);
    assign bus.gnt        = gnt_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.rdata      = rdata_q;
    assign bus.word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_prng_sched_ctrl.sv
// Scoreboard bench: stimulus queues expected {gnt, rdata}; a negedge monitor pops and compares.
module tb_prng_sched_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    prng_sched_if #(.N_REQ(4)) if0 ();
    prng_sched_if #(.N_REQ(4)) if4 ();

    prng_sched_ctrl #(.N_REQ(4)) dut (.clk(clk), .rst(rst), .bus(if0.slave));
    prng_sched_ctrl #(.N_REQ(4), .RESEED_PERIOD(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct packed {
        logic [3:0]   gnt;
        logic [127:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q4[$];
    exp_t        e0, e4;
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] ns     = 32'd0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ns = ns + 32'd1;
        if0.prng_data = {ns, ~ns, 32'h5A5AC3C3, ns ^ 32'h12345678};
        if4.prng_data = {ns ^ 32'hFFFF0000, ns, ~ns, 32'hC0DEC0DE};
    endtask

    task automatic push0(input logic [3:0] g);
        q0.push_back('{gnt: g, data: if0.prng_data});
    endtask

    task automatic push4(input logic [3:0] g);
        q4.push_back('{gnt: g, data: if4.prng_data});
    endtask

    // Ten cycles of SEED(2)+WARM(8) with busy high, then SERVE; optional reseed pulse on dut4.
    task automatic seq(input bit sel, input int pulse_at);
        for (int i = 0; i < 10; i++) begin
            check("prng_rst_n_seq", sel ? if4.prng_rst_n : if0.prng_rst_n, (i >= 2));
            check("busy_seq", sel ? if4.busy : if0.busy, 1'b1);
            if (sel && i == pulse_at) if4.reseed_req = 1'b1;
            step();
            if4.reseed_req = 1'b0;
        end
        check("busy_serve", sel ? if4.busy : if0.busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check("rvalid_vs_gnt0", if0.rvalid, (if0.gnt != 4'b0));
            if (if0.rvalid) begin
                if (q0.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_grant0: got gnt=%b want none", if0.gnt);
                end else begin
                    e0 = q0.pop_front();
                    check("gnt0", if0.gnt, e0.gnt);
                    check("rdata0", if0.rdata, e0.data);
                end
            end
            check("rvalid_vs_gnt4", if4.rvalid, (if4.gnt != 4'b0));
            if (if4.rvalid) begin
                if (q4.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_grant4: got gnt=%b want none", if4.gnt);
                end else begin
                    e4 = q4.pop_front();
                    check("gnt4", if4.gnt, e4.gnt);
                    check("rdata4", if4.rdata, e4.data);
                end
            end
        end
    end

    initial begin
        if0.req = 4'b0; if0.reseed_req = 1'b0; if0.prng_data = 128'h0;
        if4.req = 4'b0; if4.reseed_req = 1'b0; if4.prng_data = 128'h0;
        #1;
        check("rst_gnt", if0.gnt, 4'b0);
        check("rst_rvalid", if0.rvalid, 1'b0);
        check("rst_rdata", if0.rdata, 128'h0);
        check("rst_prng_rst_n", if0.prng_rst_n, 1'b0);
        check("rst_busy", if0.busy, 1'b1);
        check("rst_word_cnt", if0.word_cnt, 32'd0);

        // Release with all requesters pending; each drops once granted.
        if0.req = 4'b1111;
        step();
        rst = 1'b1;
        seq(1'b0, -1);
        push0(4'b0001); step(); if0.req = 4'b1110;
        push0(4'b0010); step(); if0.req = 4'b1100;
        push0(4'b0100); step(); if0.req = 4'b1000;
        push0(4'b1000); step(); if0.req = 4'b0000;
        check("word_cnt_4", if0.word_cnt, 32'd4);
        step(); step();

        // Two requesters held continuously alternate every cycle.
        if0.req = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            push0((k % 2 == 1) ? 4'b0100 : 4'b0001);
            step();
        end
        if0.req = 4'b0000;
        step();
        check("word_cnt_10", if0.word_cnt, 32'd10);

        // Reseed request beats a simultaneous req; req served after warm-up.
        if0.req = 4'b0010;
        if0.reseed_req = 1'b1;
        step();
        if0.reseed_req = 1'b0;
        check("word_cnt_reseed", if0.word_cnt, 32'd10);
        seq(1'b0, -1);
        push0(4'b0010); step(); if0.req = 4'b0000;
        step();
        check("word_cnt_11", if0.word_cnt, 32'd11);

        // Auto reseed after 4 grants on dut4; reseed_req during WARM ignored.
        for (int k = 0; k < 4; k++) begin
            if4.req = 4'b0001; push4(4'b0001); step();
            if4.req = 4'b0000; step();
        end
        if4.req = 4'b0001;
        seq(1'b1, 4);
        push4(4'b0001); step(); if4.req = 4'b0000; step();
        for (int k = 0; k < 2; k++) begin
            if4.req = 4'b0001; push4(4'b0001); step();
            if4.req = 4'b0000; step();
        end
        check("busy4_after_3", if4.busy, 1'b0);
        step();
        check("busy4_after_3b", if4.busy, 1'b0);
        check("word_cnt4", if4.word_cnt, 32'd7);

        // Reset while a grant is on the bus.
        if0.req = 4'b0001;
        step();
        check("gnt_pre_rst", if0.gnt, 4'b0001);
        rst = 1'b0;
        #1;
        check("mid_rst_gnt", if0.gnt, 4'b0);
        check("mid_rst_rvalid", if0.rvalid, 1'b0);
        check("mid_rst_rdata", if0.rdata, 128'h0);
        check("mid_rst_prng_rst_n", if0.prng_rst_n, 1'b0);
        check("mid_rst_busy", if0.busy, 1'b1);
        if0.req = 4'b1111;
        if4.req = 4'b0000;
        step();
        rst = 1'b1;
        seq(1'b0, -1);
        push0(4'b0001); step(); if0.req = 4'b0000;
        step();
        check("word_cnt_after_rst", if0.word_cnt, 32'd1);

        step();
        check("q0_drained", q0.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
